// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin arbitration of two write-back sources
// onto the single RF write port, with a busy-bit scoreboard for issue stalls.
module rf_wb_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rj,
   input  logic [4:0]  iss_rk,
   input  logic        iss_use_rj,
   input  logic        iss_use_rk,
   input  logic        iss_we,
   input  logic [4:0]  iss_rd,
   output logic        iss_stall,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ready,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic [31:0] busy_vec
);

   logic [31:0] r_busy;
   logic        r_last_b;
   logic        r_we;
   logic [4:0]  r_wa;
   logic [31:0] r_wd;

   logic        w_a_hs;
   logic        w_b_hs;
   logic        w_hs;
   logic        w_issue;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   logic [31:0] w_busy_nxt;

   // Readies are mutually exclusive only under contention.
   assign a_ready = ~b_valid | r_last_b;
   assign b_ready = ~a_valid | ~r_last_b;
   assign w_a_hs  = a_valid & a_ready;
   assign w_b_hs  = b_valid & b_ready;
   assign w_hs    = w_a_hs | w_b_hs;
   assign w_addr  = w_a_hs ? a_addr : b_addr;
   assign w_data  = w_a_hs ? a_data : b_data;

   assign iss_stall = iss_valid &
                      ((iss_use_rj & r_busy[iss_rj]) |
                       (iss_use_rk & r_busy[iss_rk]) |
                       (iss_we     & r_busy[iss_rd]));
   assign w_issue = iss_valid & ~iss_stall;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (w_issue && iss_we && (iss_rd != 5'd0))
         w_set = 32'd1 << iss_rd;
      if (r_we)
         w_clr = 32'd1 << r_wa;
      // A new producer owns the register even if it commits this edge.
      w_busy_nxt = ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy   <= '0;
         r_last_b <= 1'b1;
         r_we     <= 1'b0;
         r_wa     <= '0;
         r_wd     <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_hs)
            r_last_b <= w_b_hs;
         if (w_hs && (w_addr != 5'd0)) begin
            r_we <= 1'b1;
            r_wa <= w_addr;
            r_wd <= w_data;
         end else begin
            r_we <= 1'b0;
         end
      end
   end

   assign rf_we    = r_we;
   assign rf_wa    = r_wa;
   assign rf_wd    = r_wd;
   assign busy_vec = r_busy;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed plus randomized bench for rf_wb_sched against a behavioural
// model of the scoreboard, round-robin grant and write-back register.
module tb_rf_wb_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_use_rj, iss_use_rk, iss_we;
   logic [4:0]  iss_rj, iss_rk, iss_rd;
   logic        iss_stall;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] busy_vec;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   bit          m_busy[32];
   int          m_last;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          m_win;

   always #5 clk = ~clk;

   rf_wb_sched dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rj(iss_rj), .iss_rk(iss_rk),
      .iss_use_rj(iss_use_rj), .iss_use_rk(iss_use_rk),
      .iss_we(iss_we), .iss_rd(iss_rd), .iss_stall(iss_stall),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy_vec(busy_vec)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_last = 1;
      m_we = 0;
      m_wa = '0;
      m_wd = '0;
   endtask

   function automatic logic [31:0] m_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic bit m_stall();
      return iss_valid &&
             ((iss_use_rj && m_busy[iss_rj]) ||
              (iss_use_rk && m_busy[iss_rk]) ||
              (iss_we && m_busy[iss_rd]));
   endfunction

   // -1 none, 0 source A, 1 source B
   function automatic int m_winner();
      if (a_valid && !b_valid) return 0;
      if (b_valid && !a_valid) return 1;
      if (a_valid && b_valid) return 1 - m_last;
      return -1;
   endfunction

   task automatic chk_model();
      @(negedge clk);
      chk("stall", iss_stall, m_stall());
      chk("a_ready", a_ready, (!b_valid || m_last == 1));
      chk("b_ready", b_ready, (!a_valid || m_last == 0));
      chk("rf_we", rf_we, m_we);
      chk("rf_wa", rf_wa, m_wa);
      chk("rf_wd", rf_wd, m_wd);
      chk("busy", busy_vec, m_vec());
   endtask

   task automatic adv();
      bit          nb[32];
      bit          iss_ok;
      logic [4:0]  ad;
      logic [31:0] dt;
      nb = m_busy;
      iss_ok = iss_valid && !m_stall();
      if (m_we) nb[m_wa] = 0;
      if (iss_ok && iss_we && iss_rd != 0) nb[iss_rd] = 1;
      m_win = m_winner();
      @(posedge clk);
      #1;
      m_busy = nb;
      if (m_win >= 0) begin
         m_last = m_win;
         ad = (m_win == 0) ? a_addr : b_addr;
         dt = (m_win == 0) ? a_data : b_data;
         m_we = (ad != 0);
         if (ad != 0) begin
            m_wa = ad;
            m_wd = dt;
         end
      end else begin
         m_we = 0;
      end
   endtask

   task automatic tick();
      chk_model();
      adv();
   endtask

   task automatic idle_in();
      iss_valid = 0; iss_use_rj = 0; iss_use_rk = 0; iss_we = 0;
      iss_rj = 0; iss_rk = 0; iss_rd = 0;
      a_valid = 0; a_addr = 0; a_data = 0;
      b_valid = 0; b_addr = 0; b_data = 0;
   endtask

   initial begin
      bit a_pend, b_pend;
      logic [31:0] d1, d2;
      idle_in();
      rst = 1;
      m_reset();
      #1;
      chk("rst_we", rf_we, 0);
      chk("rst_busy", busy_vec, 0);
      @(posedge clk);
      #1;
      rst = 0;

      // reset then idle
      chk_model();
      chk("idle_ar", a_ready, 1);
      chk("idle_br", b_ready, 1);
      adv();

      // issue r5, dependent stall, write-back, stall release
      iss_valid = 1; iss_we = 1; iss_rd = 5;
      tick();
      iss_we = 0; iss_use_rj = 1; iss_rj = 5;
      chk_model();
      chk("r5_busy", busy_vec, 32'h20);
      chk("r5_stall", iss_stall, 1);
      adv();
      a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
      tick();
      a_valid = 0;
      chk_model();
      chk("r5_we", rf_we, 1);
      chk("r5_wa", rf_wa, 5);
      chk("r5_wd", rf_wd, 32'hDEADBEEF);
      chk("r5_stall_n1", iss_stall, 1);
      adv();
      chk_model();
      chk("r5_stall_n2", iss_stall, 0);
      adv();
      idle_in();

      // make B the last winner, then a 4-cycle tie
      b_valid = 1; b_addr = 9; b_data = 32'h9;
      tick();
      d1 = $urandom; d2 = $urandom;
      a_valid = 1; a_addr = 3; a_data = d1;
      b_valid = 1; b_addr = 4; b_data = d2;
      for (int i = 0; i < 4; i++) begin
         chk_model();
         chk("tie_ar", a_ready, (i % 2 == 0));
         chk("tie_br", b_ready, (i % 2 == 1));
         if (i > 0) chk("tie_wa", rf_wa, (i % 2 == 1) ? 3 : 4);
         adv();
      end
      idle_in();
      chk_model();
      chk("tie_wa_last", rf_wa, 4);
      chk("tie_wd_last", rf_wd, d2);
      adv();

      // r0 handling
      iss_valid = 1; iss_we = 1; iss_rd = 0;
      tick();
      idle_in();
      a_valid = 1; a_addr = 0; a_data = 32'h1234;
      chk_model();
      chk("r0_busy", busy_vec, 0);
      chk("r0_ar", a_ready, 1);
      adv();
      a_valid = 0;
      chk_model();
      chk("r0_we", rf_we, 0);
      adv();

      // same-edge set and clear of r7
      a_valid = 1; a_addr = 7; a_data = 32'h77;
      tick();
      a_valid = 0;
      iss_valid = 1; iss_we = 1; iss_rd = 7;
      chk_model();
      chk("same_we", rf_we, 1);
      chk("same_wa", rf_wa, 7);
      adv();
      chk_model();
      chk("same_busy7", busy_vec[7], 1);
      chk("waw_stall", iss_stall, 1);
      adv();
      idle_in();

      // randomized phase; held requests keep address and data
      a_pend = 0; b_pend = 0;
      for (int c = 0; c < 400; c++) begin
         iss_valid = $urandom_range(0, 1);
         iss_use_rj = $urandom_range(0, 1);
         iss_use_rk = $urandom_range(0, 1);
         iss_we = $urandom_range(0, 1);
         iss_rj = $urandom; iss_rk = $urandom; iss_rd = $urandom;
         if (!a_pend) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_addr = $urandom; a_data = $urandom;
         end
         if (!b_pend) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_addr = $urandom; b_data = $urandom;
         end
         tick();
         a_pend = a_valid && (m_win != 0);
         b_pend = b_valid && (m_win != 1);
      end
      idle_in();
      tick();

      // async reset between edges, then build busy=0xF00 with rf_we=1
      #2 rst = 1;
      #1 rst = 0;
      m_reset();
      chk("pulse_busy", busy_vec, 0);
      for (int r = 8; r < 12; r++) begin
         iss_valid = 1; iss_we = 1; iss_rd = r[4:0];
         if (r == 11) begin
            a_valid = 1; a_addr = 1; a_data = 32'hA5A5_0001;
         end
         tick();
      end
      idle_in();
      chk_model();
      chk("pre_busy", busy_vec, 32'h0000_0F00);
      chk("pre_we", rf_we, 1);
      #1 rst = 1;
      a_valid = 1; a_addr = 3; a_data = 32'h33;
      b_valid = 1; b_addr = 4; b_data = 32'h44;
      #1;
      chk("mrst_we", rf_we, 0);
      chk("mrst_wa", rf_wa, 0);
      chk("mrst_wd", rf_wd, 0);
      chk("mrst_busy", busy_vec, 0);
      chk("mrst_ar", a_ready, 1);
      chk("mrst_br", b_ready, 0);
      rst = 0;
      m_reset();
      adv();
      idle_in();
      chk_model();
      chk("post_wa", rf_wa, 3);
      chk("post_wd", rf_wd, 32'h33);
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-back scheduler and scoreboard for the CPU's 32×32 register file. It shares the file's single write port between two write-back sources: the single-cycle ALU path (A) and the long-latency load/mul-div path (B). Grants are round-robin, and the selected write is registered onto the RF write port. A busy-bit scoreboard stalls issue on read-after-write and write-after-write hazards until the pending write commits.

## Interface
- No parameters; widths fixed: 5-bit register address, 32-bit data, 32 registers.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- iss_valid  in  1  decode stage presents an instruction
- iss_rj / iss_rk  in  5 each  source register addresses
- iss_use_rj / iss_use_rk  in  1 each  source actually read
- iss_we  in  1  instruction writes iss_rd
- iss_rd  in  5  destination register address
- iss_stall  out  1  combinational; instruction must be held
- a_valid  in  1  source A write request
- a_addr  in  5  source A write address
- a_data  in  32  source A write data
- a_ready  out  1  source A request accepted this cycle
- b_valid / b_addr / b_data / b_ready  same as source A, for source B
- rf_we  out  1  registered RF write enable
- rf_wa  out  5  registered RF write address; drives the RF d-address port
- rf_wd  out  32  registered RF write data
- busy_vec  out  32  scoreboard state (debug)

## Operation
- Scoreboard: busy[31:0]; busy[0] is hard-wired 0.
- Issue:
  - iss_stall = iss_valid & ((iss_use_rj & busy[iss_rj]) | (iss_use_rk & busy[iss_rk]) | (iss_we & busy[iss_rd])).
  - Issue fires when iss_valid & !iss_stall. If it also has iss_we & iss_rd≠0, set busy[iss_rd] at the edge.
- Arbiter:
  - last_grant flag ∈ {A,B}, reset value B, so A wins the first tie.
  - Only one source valid: that source is granted.
  - Both valid: grant the source not in last_grant.
  - a_ready = !b_valid | (last_grant==B). b_ready = !a_valid | (last_grant==A). Both are combinational and independent of the source's own valid.
  - A handshake is valid & ready. On a handshake, last_grant updates to the winner. With no handshake, last_grant holds.
- Output register:
  - On a handshake with addr≠0: rf_we←1, rf_wa←addr, rf_wd←data.
  - On a handshake to r0: the handshake completes but rf_we←0 (write dropped).
  - Otherwise rf_we←0; rf_wa and rf_wd hold their last values.
- Commit: in any cycle with rf_we=1, busy[rf_wa] clears at that edge, together with the RF write.
- Simultaneous set and clear of the same register in one edge: set wins; the new producer owns the register.
- No bypass: a register committing this cycle still reads busy this cycle, so its consumer stalls one more cycle.

## Timing
- Reset (async, immediate): rf_we=0, rf_wa=0, rf_wd=0, busy_vec=0, last_grant=B. The iss_stall, a_ready and b_ready outputs are then determined purely by their inputs.
- Reset mid-operation drops any registered write and all busy bits. Requests in flight are the sources' responsibility.
- Latency from handshake edge N:
  - rf_we is high during cycle N+1.
  - The RF holds the new value and busy clears after edge N+1.
  - A dependent instruction sees iss_stall=0 in cycle N+2.
- Throughput: one write per cycle. Under continuous contention, A and B alternate strictly.
- A source holding valid without ready must keep addr and data stable. The block does not latch unaccepted requests.

## Test plan
- Reset then idle: rf_we=0, busy_vec=0, a_ready=b_ready=1.
- Issue r5 (iss_we=1, iss_rd=5):
  - busy_vec=0x20 next cycle.
  - Dependent issue with rj=5 stalls.
  - a_valid, a_addr=5, a_data=0xDEADBEEF accepted at edge N.
  - rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle N+1.
  - Stall drops in cycle N+2.
- Tie arbitration: A→r3 and B→r4 held valid for 4 cycles. Grants go A, B, A, B with a_ready/b_ready alternating; rf_wa sequence is 3, 4, 3, 4.
- r0 handling:
  - Issue with iss_rd=0 leaves busy_vec=0.
  - a_addr=0 write: a_ready=1 and rf_we stays 0.
- Same-edge conflict: rf_we=1, rf_wa=7 while issuing iss_rd=7 → busy[7]=1 after the edge. WAW issue to r7 stalls.
- Async reset mid-stream:
  - Setup: busy_vec=0x0000_0F00 and rf_we=1.
  - Assert rst between edges → all outputs reset immediately.
  - Then A wins the first tie.
